onehot_stream_encoder: RTL



---
 rtl/onehot_stream_encoder_pkg.sv | 30 +++
 rtl/priority_find_nbit.sv | 40 ++++
 rtl/onehot_stream_encoder.sv | 103 ++++++++++
 3 files changed

// File: rtl/onehot_stream_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_stream_encoder_pkg
// Description : Shared types, width constants and bit helpers for the encoder.
// Revision    : 1.0
// ============================================================================
package onehot_stream_encoder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int unsigned C_DEFAULT_N = 3;
    localparam int unsigned C_DEFAULT_W = 1 << C_DEFAULT_N;
    localparam int unsigned C_MAX_W     = 256;

    function automatic int unsigned vec_width(input int unsigned n);
        return 1 << n;
    endfunction

    // True when exactly one bit is set; callers zero-extend to C_MAX_W.
    function automatic logic is_single_bit(input logic [C_MAX_W-1:0] v);
        logic [C_MAX_W-1:0] dec;
        dec = v - {{(C_MAX_W-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & dec) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_find_nbit.sv
`default_nettype none
// ============================================================================
// Module      : priority_find_nbit
// Description : Combinational lowest/highest set-bit finder over 2**N bits.
// Revision    : 1.0
// ============================================================================
module priority_find_nbit #(
    parameter int unsigned N         = 3,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic [2**N-1:0] vec,
    output logic [N-1:0]    pos,
    output logic            any
);

    localparam int unsigned W = 1 << N;

    assign any = |vec;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            // Ascending scan: the last hit is the highest set bit.
            always_comb begin
                pos = '0;
                for (int i = 0; i < int'(W); i++) begin
                    if (vec[i]) pos = i[N-1:0];
                end
            end
        end else begin : g_lsb_first
            always_comb begin
                pos = '0;
                for (int i = int'(W) - 1; i >= 0; i--) begin
                    if (vec[i]) pos = i[N-1:0];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/onehot_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_stream_encoder
// Description : Serialises every set bit of a 2**N request vector into indices.
// Revision    : 1.0
// ============================================================================
module onehot_stream_encoder
    import onehot_stream_encoder_pkg::*;
#(
    parameter int unsigned N         = 3,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**N-1:0] req,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    idx,
    output logic            last,
    output logic            empty
);

    localparam int unsigned W = 1 << N;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_pending;
    logic [W-1:0]   w_pending_nxt;
    logic [W-1:0]   w_clear;
    logic           r_zero;
    logic           w_zero_nxt;
    logic [N-1:0]   w_pos;
    logic           w_any;
    logic           w_single;
    logic           w_last;

    priority_find_nbit #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_find (
        .vec (r_pending),
        .pos (w_pos),
        .any (w_any)
    );

    assign w_single = w_any & is_single_bit(C_MAX_W'(r_pending));
    assign w_last   = w_single | r_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_zero    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_zero    <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_zero_nxt    = r_zero;
        w_clear       = '0;
        w_clear[w_pos] = 1'b1;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_pending_nxt = req;
                    w_zero_nxt    = (req == '0);
                    w_state_nxt   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_pending_nxt = r_pending & ~w_clear;
                    if (w_last) begin
                        w_pending_nxt = '0;
                        w_zero_nxt    = 1'b0;
                        w_state_nxt   = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pending_nxt = '0;
                w_zero_nxt    = 1'b0;
            end
        endcase
    end

    // Beat fields come straight from registered state, so they hold under backpressure.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == EMIT);
    assign idx       = w_pos;
    assign last      = out_valid & w_last;
    assign empty     = out_valid & r_zero;

endmodule
`default_nettype wire
